// File: rtl/aes_chk_pkg.sv
// Shared types and constants for the AES result checker: FSM encoding, block geometry
// and a saturating-increment helper.
package aes_chk_pkg;

    localparam int WORDS_PER_BLOCK = 4;
    localparam int WORD_W          = 32;
    localparam int BLOCK_W         = WORDS_PER_BLOCK * WORD_W;
    localparam int BEAT_W          = $clog2(WORDS_PER_BLOCK);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        RECV = 2'd2,
        GOLD = 2'd3
    } state_t;

    // Increment that sticks at the all-ones value of a width-bit counter.
    function automatic logic [31:0] SAT_INC(input logic [31:0] value, input int width);
        logic [31:0] max_val;
        max_val = (width >= 32) ? '1 : ((32'd1 << width) - 32'd1);
        return (value >= max_val) ? value : value + 32'd1;
    endfunction

endpackage

// File: rtl/aes_word_serdes.sv
// Block-to-word serialiser and word-to-block deserialiser for the AES result checker,
// sharing one beat counter (transmit and receive never overlap).
module aes_word_serdes
    import aes_chk_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic [BLOCK_W-1:0] load_data,
    input  logic               tx_step,
    input  logic               rx_step,
    input  logic [WORD_W-1:0]  rx_word,
    input  logic               force_ones,
    output logic [WORD_W-1:0]  tx_word,
    output logic [BLOCK_W-1:0] got,
    output logic [BEAT_W-1:0]  beat
);

    logic [BLOCK_W-1:0] pt_reg;

    // NOTE: sequential state uses non-blocking assignments only; the data registers are
    // reset too because the checker's outputs must all read zero straight after reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pt_reg <= '0;
            got    <= '0;
            beat   <= '0;
        end else begin
            if (load) begin
                pt_reg <= load_data;
            end

            if (force_ones) begin
                got <= '1;
            end else if (rx_step) begin
                got <= {got[BLOCK_W-WORD_W-1:0], rx_word};
            end

            // The counter wraps to 0 after the fourth beat, ready for the next phase.
            if (load || force_ones) begin
                beat <= '0;
            end else if (tx_step || rx_step) begin
                beat <= beat + 1'b1;
            end
        end
    end

    // Most significant word goes out first.
    assign tx_word = pt_reg[WORD_W*(WORDS_PER_BLOCK-1-int'(beat)) +: WORD_W];

endmodule

// File: rtl/aes_result_checker.sv
// Streams plaintext blocks to an AES chip, compares its responses with golden ciphertext
// and keeps pass/fail statistics. Optional receive timeout: define CHECKER_TIMEOUT_EN.
module aes_result_checker
    import aes_chk_pkg::*;
#(
    parameter int CNT_W = 16
`ifdef CHECKER_TIMEOUT_EN
    , parameter int TIMEOUT = 1024
`endif
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               data_empty,
    input  logic [127:0]       data,
    output logic               data_require,
    input  logic               result_empty,
    input  logic [127:0]       result,
    output logic               result_require,
    output logic [31:0]        tx_word,
    output logic               tx_valid,
    input  logic               tx_ready,
    input  logic [31:0]        rx_word,
    input  logic               rx_valid,
    output logic               rx_ready,
    output logic [CNT_W-1:0]   pass_cnt,
    output logic [CNT_W-1:0]   fail_cnt,
    output logic               mismatch,
    output logic [127:0]       first_exp,
    output logic [127:0]       first_got,
`ifdef CHECKER_TIMEOUT_EN
    output logic               timeout_flag,
`endif
    output logic               busy
);

    state_t             state;
    logic [BEAT_W-1:0]  beat;
    logic [BLOCK_W-1:0] got;
    logic [WORD_W-1:0]  serdes_word;
    logic               last_beat;
    logic               timeout_hit;

    assign last_beat = (beat == BEAT_W'(WORDS_PER_BLOCK - 1));

    // FIFO pops are gated by rst_n so a FIFO is never drained while the FSM is held in reset.
    assign data_require   = rst_n && (state == IDLE) && start && !data_empty;
    assign result_require = rst_n && (state == GOLD) && !result_empty;
    assign tx_valid       = (state == SEND);
    assign rx_ready       = (state == RECV);
    assign busy           = (state != IDLE);
    assign tx_word        = tx_valid ? serdes_word : '0;

    aes_word_serdes u_serdes (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (data_require),
        .load_data  (data),
        .tx_step    (tx_valid && tx_ready),
        .rx_step    (rx_ready && rx_valid),
        .rx_word    (rx_word),
        .force_ones (timeout_hit),
        .tx_word    (serdes_word),
        .got        (got),
        .beat       (beat)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            pass_cnt  <= '0;
            fail_cnt  <= '0;
            mismatch  <= 1'b0;
            first_exp <= '0;
            first_got <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && !data_empty) state <= SEND;
                end
                SEND: begin
                    if (tx_ready && last_beat) state <= RECV;
                end
                RECV: begin
                    if (rx_valid) begin
                        if (last_beat) state <= GOLD;
                    end else if (timeout_hit) begin
                        state <= GOLD;
                    end
                end
                GOLD: begin
                    if (!result_empty) begin
                        state <= IDLE;
                        if (result == got) begin
                            pass_cnt <= CNT_W'(SAT_INC(32'(pass_cnt), CNT_W));
                        end else begin
                            fail_cnt <= CNT_W'(SAT_INC(32'(fail_cnt), CNT_W));
                            // Only the first failure since reset is captured.
                            if (!mismatch) begin
                                mismatch  <= 1'b1;
                                first_exp <= result;
                                first_got <= got;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef CHECKER_TIMEOUT_EN
    localparam int TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [TO_W-1:0] to_cnt;

    // Silent chip: give up after TIMEOUT idle RECV cycles and fail the block with all-ones.
    assign timeout_hit = (state == RECV) && !rx_valid && (to_cnt == TO_W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            to_cnt       <= '0;
            timeout_flag <= 1'b0;
        end else begin
            if ((state == RECV) && !rx_valid && !timeout_hit) begin
                to_cnt <= to_cnt + 1'b1;
            end else begin
                to_cnt <= '0;
            end
            if (timeout_hit) timeout_flag <= 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

endmodule
